// File: rtl/xor_frame_ctrl.sv
// rtl/xor_frame_ctrl.sv - serialises a captured key and message into an XOR engine, then waits for done
// Optional WAIT-state timeout is enabled by defining XOR_FRAME_CTRL_TIMEOUT_EN.
module xor_frame_ctrl #(
   parameter int KEY_W   = 8,
   parameter int MSG_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iEn,
   input  logic                     iTick,
   input  logic                     iStart,
   input  logic                     iAbort,
   input  logic [KEY_W-1:0]         iKey,
   input  logic [$clog2(KEY_W)-1:0] iKey_len,
   input  logic [MSG_W-1:0]         iMsg,
   input  logic [$clog2(MSG_W)-1:0] iMsg_len,
   input  logic                     iDone_flag,
   output logic                     oLoad_key,
   output logic                     oLoad_msg,
   output logic                     oData_ser,
   output logic                     oBusy,
   output logic                     oDone,
   output logic                     oErr
);

   localparam int CW = $clog2(((KEY_W > MSG_W) ? KEY_W : MSG_W) + 1);

   typedef enum logic [2:0] {IDLE, KEY, GAP, MSG, WAIT, FIN} state_t;

   state_t           state, state_nx;
   logic [KEY_W-1:0] key_q, key_sh;
   logic [MSG_W-1:0] msg_q, msg_sh;
   logic [CW-1:0]    key_len_q, msg_len_q, key_len_eff, msg_len_eff;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             capture;

`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt, to_cnt_nx;
   logic          to_fire, err_q;
`endif

   // A zero length field selects the full register width.
   assign key_len_eff = (iKey_len == '0) ? CW'(KEY_W) : CW'(iKey_len);
   assign msg_len_eff = (iMsg_len == '0) ? CW'(MSG_W) : CW'(iMsg_len);
   assign capture     = (state == IDLE) & iEn & iStart;

   // Shifting by the bit position keeps every access at the MSB.
   assign key_sh = key_q << cnt;
   assign msg_sh = msg_q << cnt;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
      to_cnt_nx = to_cnt;
      to_fire   = 1'b0;
`endif
      if ((state != IDLE) && iAbort) begin
         state_nx = IDLE;
         cnt_nx   = '0;
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
         to_cnt_nx = '0;
`endif
      end else if (iEn) begin
         case (state)
            IDLE: begin
               if (iStart) begin
                  state_nx = KEY;
                  cnt_nx   = '0;
               end
            end
            KEY: begin
               if (iTick) begin
                  if (cnt + CW'(1) >= key_len_q) begin
                     state_nx = GAP;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
            end
            GAP: begin
               if (iTick) state_nx = MSG;
            end
            MSG: begin
               if (iTick) begin
                  if (cnt + CW'(1) >= msg_len_q) begin
                     state_nx = WAIT;
                     cnt_nx   = '0;
                  end else begin
                     cnt_nx = cnt + CW'(1);
                  end
               end
            end
            WAIT: begin
               if (iDone_flag) begin
                  state_nx = FIN;
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
                  to_cnt_nx = '0;
               end else if (iTick) begin
                  if (to_cnt + TW'(1) >= TW'(TIMEOUT)) begin
                     state_nx  = IDLE;
                     to_cnt_nx = '0;
                     to_fire   = 1'b1;
                  end else begin
                     to_cnt_nx = to_cnt + TW'(1);
                  end
`endif
               end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state     <= IDLE;
         cnt       <= '0;
         key_q     <= '0;
         msg_q     <= '0;
         key_len_q <= '0;
         msg_len_q <= '0;
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
         to_cnt    <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (capture) begin
            key_q     <= iKey;
            msg_q     <= iMsg;
            key_len_q <= key_len_eff;
            msg_len_q <= msg_len_eff;
         end
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
         to_cnt <= to_cnt_nx;
         err_q  <= to_fire;
`endif
      end
   end

   assign oLoad_key = (state == KEY);
   assign oLoad_msg = (state == MSG);
   assign oData_ser = (state == KEY) ? key_sh[KEY_W-1] :
                      (state == MSG) ? msg_sh[MSG_W-1] : 1'b0;
   assign oBusy     = (state != IDLE);
   assign oDone     = (state == FIN);
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
   assign oErr      = err_q;
`else
   assign oErr      = 1'b0;
`endif

endmodule

// File: tb/tb_xor_frame_ctrl.sv
// tb/tb_xor_frame_ctrl.sv - directed-vector bench for xor_frame_ctrl
module tb_xor_frame_ctrl;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic        iEn = 1'b0;
   logic        iTick = 1'b0;
   logic        iStart = 1'b0;
   logic        iAbort = 1'b0;
   logic        iDone_flag = 1'b0;
   logic [7:0]  iKey = '0;
   logic [2:0]  iKey_len = '0;
   logic [15:0] iMsg = '0;
   logic [3:0]  iMsg_len = '0;
   logic        oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr;

   int vec = 0;
   int errs = 0;

   always #5 iClk = ~iClk;

   xor_frame_ctrl #(.KEY_W(8), .MSG_W(16), .TIMEOUT(5)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iTick(iTick), .iStart(iStart),
      .iAbort(iAbort), .iKey(iKey), .iKey_len(iKey_len), .iMsg(iMsg),
      .iMsg_len(iMsg_len), .iDone_flag(iDone_flag), .oLoad_key(oLoad_key),
      .oLoad_msg(oLoad_msg), .oData_ser(oData_ser), .oBusy(oBusy),
      .oDone(oDone), .oErr(oErr)
   );

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // one qualified tick followed by three idle cycles
   task automatic tick();
      iTick = 1'b1;
      step();
      iTick = 1'b0;
      repeat (3) step();
   endtask

   task automatic start(input logic [7:0] k, input logic [2:0] kl,
                        input logic [15:0] m, input logic [3:0] ml);
      iKey = k; iKey_len = kl; iMsg = m; iMsg_len = ml;
      iStart = 1'b1;
      step();
      iStart = 1'b0;
   endtask

   task automatic test_reset();
      iRst = 1'b0; iEn = 1'b1;
      repeat (2) step();
      vec++;
      if ({oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr} !== 6'b0) begin
         errs++;
         $display("FAIL reset_outputs: got %b, want 000000",
                  {oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr});
      end
      iRst = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      logic [3:0] kb;
      logic [7:0] mb;
      kb = 4'b1011;
      mb = 8'b10001001;
      start(8'hB0, 3'd4, 16'h8900, 4'd8);
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (oLoad_key !== 1'b1 || oLoad_msg !== 1'b0 || oData_ser !== kb[3-i] || oBusy !== 1'b1) begin
            errs++;
            $display("FAIL nom_key_bit%0d: load_key=%b load_msg=%b data=%b busy=%b, want 1 0 %b 1",
                     i, oLoad_key, oLoad_msg, oData_ser, oBusy, kb[3-i]);
         end
         tick();
      end
      vec++;
      if ({oLoad_key, oLoad_msg, oData_ser, oBusy} !== 4'b0001) begin
         errs++;
         $display("FAIL nom_gap: got %b, want 0001", {oLoad_key, oLoad_msg, oData_ser, oBusy});
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         vec++;
         if (oLoad_msg !== 1'b1 || oLoad_key !== 1'b0 || oData_ser !== mb[7-i]) begin
            errs++;
            $display("FAIL nom_msg_bit%0d: load_msg=%b load_key=%b data=%b, want 1 0 %b",
                     i, oLoad_msg, oLoad_key, oData_ser, mb[7-i]);
         end
         tick();
      end
      vec++;
      if ({oLoad_key, oLoad_msg, oData_ser, oBusy, oDone} !== 5'b00010) begin
         errs++;
         $display("FAIL nom_wait: got %b, want 00010", {oLoad_key, oLoad_msg, oData_ser, oBusy, oDone});
      end
      repeat (3) tick();
      iDone_flag = 1'b1;
      step();
      iDone_flag = 1'b0;
      vec++;
      if (oDone !== 1'b1 || oBusy !== 1'b1) begin
         errs++;
         $display("FAIL nom_done_pulse: done=%b busy=%b, want 1 1", oDone, oBusy);
      end
      step();
      vec++;
      if (oDone !== 1'b0 || oBusy !== 1'b0) begin
         errs++;
         $display("FAIL nom_after_done: done=%b busy=%b, want 0 0", oDone, oBusy);
      end
   endtask

   task automatic test_zero_len();
      logic [7:0]  kk;
      logic [15:0] mm;
      int nk, nm, total, bad;
      kk = 8'hA5; mm = 16'h1234;
      nk = 0; nm = 0; total = 0; bad = 0;
      start(kk, 3'd0, mm, 4'd0);
      while (oLoad_key === 1'b1 && nk < 40) begin
         if (nk < 8 && oData_ser !== kk[7-nk]) bad++;
         tick(); nk++; total++;
      end
      vec++;
      if (nk !== 8) begin
         errs++;
         $display("FAIL zero_key_ticks: got %0d, want 8", nk);
      end
      tick(); total++;
      while (oLoad_msg === 1'b1 && nm < 40) begin
         if (nm < 16 && oData_ser !== mm[15-nm]) bad++;
         tick(); nm++; total++;
      end
      vec++;
      if (nm !== 16) begin
         errs++;
         $display("FAIL zero_msg_ticks: got %0d, want 16", nm);
      end
      vec++;
      if (total !== 25 || {oLoad_key, oLoad_msg, oBusy} !== 3'b001) begin
         errs++;
         $display("FAIL zero_total_to_wait: ticks=%0d flags=%b, want 25 001",
                  total, {oLoad_key, oLoad_msg, oBusy});
      end
      vec++;
      if (bad !== 0) begin
         errs++;
         $display("FAIL zero_bits: %0d wrong serial bits, want 0", bad);
      end
      iAbort = 1'b1;
      step();
      iAbort = 1'b0;
   endtask

   task automatic test_abort();
      int seen_done;
      seen_done = 0;
      start(8'hB0, 3'd4, 16'h8900, 4'd8);
      repeat (8) tick();
      vec++;
      if (oLoad_msg !== 1'b1 || oData_ser !== 1'b0) begin
         errs++;
         $display("FAIL abort_at_bit3: load_msg=%b data=%b, want 1 0", oLoad_msg, oData_ser);
      end
      iAbort = 1'b1; iDone_flag = 1'b1; iTick = 1'b1;
      step();
      iAbort = 1'b0; iDone_flag = 1'b0; iTick = 1'b0;
      vec++;
      if ({oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr} !== 6'b0) begin
         errs++;
         $display("FAIL abort_outputs: got %b, want 000000",
                  {oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr});
      end
      repeat (3) begin
         step();
         if (oDone === 1'b1) seen_done++;
      end
      vec++;
      if (seen_done !== 0) begin
         errs++;
         $display("FAIL abort_no_done: saw %0d done cycles, want 0", seen_done);
      end
   endtask

   task automatic test_restart_freeze();
      logic [3:0] kb;
      logic [7:0] mb;
      kb = 4'b1011;
      mb = 8'b10001001;
      start(8'hB0, 3'd4, 16'h8900, 4'd8);
      tick();
      iKey = 8'h4F; iMsg = 16'h7777; iKey_len = 3'd1; iMsg_len = 4'd2;
      iStart = 1'b1;
      step();
      iStart = 1'b0;
      for (int i = 1; i < 4; i++) begin
         vec++;
         if (oLoad_key !== 1'b1 || oData_ser !== kb[3-i]) begin
            errs++;
            $display("FAIL restart_key_bit%0d: load_key=%b data=%b, want 1 %b",
                     i, oLoad_key, oData_ser, kb[3-i]);
         end
         tick();
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (oLoad_msg !== 1'b1 || oData_ser !== mb[7-i]) begin
            errs++;
            $display("FAIL restart_msg_bit%0d: load_msg=%b data=%b, want 1 %b",
                     i, oLoad_msg, oData_ser, mb[7-i]);
         end
         tick();
      end
      iEn = 1'b0; iTick = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         vec++;
         if (oLoad_msg !== 1'b1 || oData_ser !== 1'b1 || oBusy !== 1'b1) begin
            errs++;
            $display("FAIL freeze_cycle%0d: load_msg=%b data=%b busy=%b, want 1 1 1",
                     c, oLoad_msg, oData_ser, oBusy);
         end
      end
      iTick = 1'b0; iEn = 1'b1;
      for (int i = 4; i < 8; i++) begin
         vec++;
         if (oLoad_msg !== 1'b1 || oData_ser !== mb[7-i]) begin
            errs++;
            $display("FAIL resume_msg_bit%0d: load_msg=%b data=%b, want 1 %b",
                     i, oLoad_msg, oData_ser, mb[7-i]);
         end
         tick();
      end
      vec++;
      if ({oLoad_key, oLoad_msg, oBusy} !== 3'b001) begin
         errs++;
         $display("FAIL resume_wait: got %b, want 001", {oLoad_key, oLoad_msg, oBusy});
      end
      iDone_flag = 1'b1;
      step();
      iDone_flag = 1'b0;
      vec++;
      if (oDone !== 1'b1) begin
         errs++;
         $display("FAIL resume_done: got %b, want 1", oDone);
      end
      step();
   endtask

   task automatic test_timeout();
      start(8'h80, 3'd1, 16'h8000, 4'd1);
      repeat (3) tick();
      vec++;
      if ({oLoad_key, oLoad_msg, oBusy, oErr} !== 4'b0010) begin
         errs++;
         $display("FAIL to_wait_entry: got %b, want 0010", {oLoad_key, oLoad_msg, oBusy, oErr});
      end
`ifdef XOR_FRAME_CTRL_TIMEOUT_EN
      for (int i = 1; i < 5; i++) begin
         tick();
         vec++;
         if (oErr !== 1'b0 || oBusy !== 1'b1) begin
            errs++;
            $display("FAIL to_early_tick%0d: err=%b busy=%b, want 0 1", i, oErr, oBusy);
         end
      end
      iTick = 1'b1;
      step();
      iTick = 1'b0;
      vec++;
      if (oErr !== 1'b1 || oBusy !== 1'b0 || oDone !== 1'b0) begin
         errs++;
         $display("FAIL to_err_pulse: err=%b busy=%b done=%b, want 1 0 0", oErr, oBusy, oDone);
      end
      step();
      vec++;
      if (oErr !== 1'b0) begin
         errs++;
         $display("FAIL to_err_width: got %b, want 0", oErr);
      end
`else
      repeat (20) tick();
      vec++;
      if (oBusy !== 1'b1 || oErr !== 1'b0) begin
         errs++;
         $display("FAIL hold_in_wait: busy=%b err=%b, want 1 0", oBusy, oErr);
      end
      iAbort = 1'b1;
      step();
      iAbort = 1'b0;
`endif
   endtask

   task automatic test_reset_mid_gap();
      logic [2:0] kb;
      logic [1:0] mb;
      kb = 3'b011;
      mb = 2'b11;
      start(8'hB0, 3'd4, 16'h8900, 4'd8);
      repeat (4) tick();
      vec++;
      if ({oLoad_key, oLoad_msg, oBusy} !== 3'b001) begin
         errs++;
         $display("FAIL rst_gap_entry: got %b, want 001", {oLoad_key, oLoad_msg, oBusy});
      end
      #2;
      iRst = 1'b0;
      #1;
      vec++;
      if ({oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr} !== 6'b0) begin
         errs++;
         $display("FAIL rst_async_outputs: got %b, want 000000",
                  {oLoad_key, oLoad_msg, oData_ser, oBusy, oDone, oErr});
      end
      step();
      iRst = 1'b1;
      start(8'h60, 3'd3, 16'hC000, 4'd2);
      for (int i = 0; i < 3; i++) begin
         vec++;
         if (oLoad_key !== 1'b1 || oData_ser !== kb[2-i]) begin
            errs++;
            $display("FAIL rst_new_key_bit%0d: load_key=%b data=%b, want 1 %b",
                     i, oLoad_key, oData_ser, kb[2-i]);
         end
         tick();
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         vec++;
         if (oLoad_msg !== 1'b1 || oData_ser !== mb[1-i]) begin
            errs++;
            $display("FAIL rst_new_msg_bit%0d: load_msg=%b data=%b, want 1 %b",
                     i, oLoad_msg, oData_ser, mb[1-i]);
         end
         tick();
      end
      iDone_flag = 1'b1;
      step();
      iDone_flag = 1'b0;
      vec++;
      if (oDone !== 1'b1 || oBusy !== 1'b1) begin
         errs++;
         $display("FAIL rst_new_done: done=%b busy=%b, want 1 1", oDone, oBusy);
      end
      step();
      vec++;
      if (oBusy !== 1'b0) begin
         errs++;
         $display("FAIL rst_new_idle: busy=%b, want 0", oBusy);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero_len();
      test_abort();
      test_restart_freeze();
      test_timeout();
      test_reset_mid_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule

// File: doc/xor_frame_ctrl.md
XOR_FRAME_CTRL -- requirements
Module: xor_frame_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_W, default 8, meaning key register width in bits.
REQ-002 The block SHALL have parameter MSG_W, default 16, meaning message register width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning maximum ticks spent waiting for engine done.
REQ-004 The block SHALL have port iClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iRst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port iEn, input, 1 bit: global enable; low freezes all state and counters.
REQ-007 The block SHALL have port iTick, input, 1 bit: one-iClk-cycle bit-rate strobe.
REQ-008 The block SHALL have port iStart, input, 1 bit: request a frame.
REQ-009 The block SHALL have port iAbort, input, 1 bit: cancel the current frame.
REQ-010 The block SHALL have port iKey, input, KEY_W bits: parallel key, sent MSB first.
REQ-011 The block SHALL have port iKey_len, input, clog2(KEY_W) bits: key bit count; 0 means KEY_W.
REQ-012 The block SHALL have port iMsg, input, MSG_W bits: parallel message, sent MSB first.
REQ-013 The block SHALL have port iMsg_len, input, clog2(MSG_W) bits: message bit count; 0 means MSG_W.
REQ-014 The block SHALL have port iDone_flag, input, 1 bit: XOR engine completion, synchronous to iClk.
REQ-015 The block SHALL have ports oLoad_key, oLoad_msg and oData_ser, outputs, 1 bit each: serial load controls and data driven into the XOR engine.
REQ-016 The block SHALL have ports oBusy, oDone and oErr, outputs, 1 bit each: frame in progress; one-cycle success pulse; one-cycle timeout pulse.

Function
REQ-017 The FSM SHALL have states IDLE, KEY, GAP, MSG, WAIT and FIN.
REQ-018 In IDLE, iStart=1 with iEn=1 SHALL capture iKey, iMsg and both effective lengths, and enter KEY on the next edge; oBusy SHALL be 1 from that edge.
REQ-019 iStart outside IDLE SHALL be ignored; captured operands SHALL NOT change mid-frame.
REQ-020 In KEY, oLoad_key SHALL be 1 and oData_ser SHALL equal the current key bit; each qualified tick (iEn & iTick) SHALL advance to the next bit.
REQ-021 After the tick consuming the last key bit, the FSM SHALL enter GAP with oLoad_key=0 and oData_ser=0 for exactly one qualified tick, then enter MSG.
REQ-022 MSG SHALL behave as KEY, using oLoad_msg and the message bits; after the last message tick it SHALL enter WAIT with both load outputs 0.
REQ-023 In WAIT, iDone_flag=1 with iEn=1 SHALL enter FIN; FIN SHALL assert oDone for exactly one cycle, then enter IDLE with oBusy=0.
REQ-024 iAbort=1 in any non-IDLE state SHALL enter IDLE on the next edge with all outputs 0 and no oDone/oErr pulse; iAbort SHALL take priority over iDone_flag and ticks in the same cycle.
REQ-025 iEn=0 SHALL hold state, bit counters and outputs unchanged; iAbort SHALL still act.
REQ-026 Bit counters SHALL saturate at the effective length and SHALL never index beyond KEY_W-1 or MSG_W-1.
REQ-027 Total ticks from capture to WAIT entry SHALL be key_len + 1 + msg_len.

Reset
REQ-028 iRst=0 SHALL immediately force state IDLE, all counters 0, and oLoad_key, oLoad_msg, oData_ser, oBusy, oDone and oErr all to 0, regardless of iClk.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL accept a new iStart on the first enabled cycle.

Configuration
REQ-030 With macro XOR_FRAME_CTRL_TIMEOUT_EN defined, WAIT SHALL count qualified ticks; reaching TIMEOUT without iDone_flag SHALL pulse oErr for one cycle and enter IDLE, and if iDone_flag and the timeout coincide, done SHALL win.
REQ-031 Without XOR_FRAME_CTRL_TIMEOUT_EN, WAIT SHALL persist until iDone_flag or iAbort, oErr SHALL be constant 0, and no timeout counter SHALL exist.

Verification
REQ-032 Nominal frame: key=8'hB0 len 4, msg=16'h8900 len 8, tick every 4 cycles -> oData_ser 1011 under oLoad_key, one GAP tick, 10001001 under oLoad_msg; iDone_flag 3 ticks later -> single oDone pulse, oBusy=0.
REQ-033 Zero lengths: iKey_len=0, iMsg_len=0 -> 8 key ticks and 16 message ticks, 25 ticks to WAIT.
REQ-034 Abort on message bit 3 together with iDone_flag=1 -> IDLE next edge, all outputs 0, no oDone.
REQ-035 iStart re-pulsed during KEY with a different iKey -> serial stream unchanged; iEn low for 10 cycles mid-MSG -> oData_ser and the bit position frozen.
REQ-036 With the macro and TIMEOUT=5, iDone_flag held 0 -> oErr pulse exactly 5 qualified ticks after WAIT entry; without the macro -> oBusy stays 1 indefinitely.
REQ-037 iRst pulled low between clock edges during GAP -> all outputs 0 before the next edge; a new frame after release is correct.
